// File: rtl/cpu_ctrl_pkg.sv
// Shared controller package: arbiter state encoding, ISA opcode constants
// and the default instruction-memory geometry used across the CPU slice.
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  // Instruction-memory port arbiter states.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    DRAIN    = 2'b01,
    HOST_OWN = 2'b10,
    RELEASE  = 2'b11
  } arb_state_t;

  // ISA opcodes (upper nibble of an instruction word).
  typedef logic [3:0] opcode_t;
  localparam opcode_t OP_NOP  = 4'b0000;
  localparam opcode_t OP_HALT = 4'b1111;

  function automatic opcode_t opcode_of(input logic [DATA_W_DEF-1:0] instr);
    return instr[DATA_W_DEF-1 -: 4];
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// 4-bit loadable down-counter with zero flag, used by the arbiter to time
// both the drain window and the core-reset pulse.
// Ports:
//   Clk, reset - clock, asynchronous active-high reset (count clears to 0)
//   load       - load load_val (has priority over dec)
//   load_val   - value to load
//   dec        - decrement by one; holds at zero
//   zero       - count is zero
module arb_hold_timer (
  input  logic       Clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_host_arbiter.sv
// Arbiter sharing the single-port instruction memory between the core fetch
// path and an external host program loader. A host session stalls the core,
// drains in-flight fetches, hands the port to the host, then pulses CoreRst
// so the core restarts from the freshly loaded program.
// Ports:
//   Clk, reset                 - clock, asynchronous active-high reset
//   HostReq/HostWe/HostAddr/HostWData - host session request and access
//   HostGnt, HostRValid        - host owns port / read data valid (registered)
//   PC, FetchEn                - core fetch address and request
//   CoreHold, CoreRst          - core stall and post-session reset (registered)
//   MemEn/MemWe/MemAddr/MemWData - memory port
//   LoadCount                  - saturating count of host writes last session
module imem_host_arbiter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned RST_CYC   = 3
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              HostReq,
  input  logic              HostWe,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWData,
  output logic              HostGnt,
  output logic              HostRValid,
  input  logic [ADDR_W-1:0] PC,
  input  logic              FetchEn,
  output logic              CoreHold,
  output logic              CoreRst,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic [ADDR_W:0]   LoadCount
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);
  localparam logic [3:0] RST_LOAD   = 4'(RST_CYC - 1);

  arb_state_t state, state_next;

  logic            gnt_next;
  logic            rvalid_next;
  logic            hold_next;
  logic            crst_next;
  logic [ADDR_W:0] count_next;

  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_dec;
  logic       tmr_zero;

  arb_hold_timer u_tmr (
    .Clk      (Clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      HostGnt    <= 1'b0;
      HostRValid <= 1'b0;
      CoreHold   <= 1'b0;
      CoreRst    <= 1'b0;
      LoadCount  <= '0;
    end else begin
      state      <= state_next;
      HostGnt    <= gnt_next;
      HostRValid <= rvalid_next;
      CoreHold   <= hold_next;
      CoreRst    <= crst_next;
      LoadCount  <= count_next;
    end
  end

  // Next-state and registered-output decisions.
  always_comb begin
    state_next  = state;
    gnt_next    = HostGnt;
    rvalid_next = 1'b0;
    hold_next   = CoreHold;
    crst_next   = CoreRst;
    count_next  = LoadCount;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    case (state)
      RUN: begin
        if (HostReq) begin
          state_next = DRAIN;
          hold_next  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = DRAIN_LOAD;
        end
      end

      DRAIN: begin
        if (!HostReq) begin
          // Host gave up before the grant: resume the core untouched.
          state_next = RUN;
          hold_next  = 1'b0;
        end else if (tmr_zero) begin
          state_next = HOST_OWN;
          gnt_next   = 1'b1;
          count_next = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      HOST_OWN: begin
        if (!HostReq) begin
          state_next = RELEASE;
          gnt_next   = 1'b0;
          crst_next  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = RST_LOAD;
        end else if (HostWe) begin
          if (LoadCount != '1) begin
            count_next = LoadCount + (ADDR_W + 1)'(1);
          end
        end else begin
          rvalid_next = 1'b1;
        end
      end

      RELEASE: begin
        if (tmr_zero) begin
          state_next = RUN;
          crst_next  = 1'b0;
          hold_next  = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_next = RUN;
        gnt_next   = 1'b0;
        hold_next  = 1'b0;
        crst_next  = 1'b0;
      end
    endcase
  end

  // Memory port mux; fetches outside RUN are dropped while the core is held.
  always_comb begin
    MemEn    = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      RUN: begin
        MemEn   = FetchEn;
        MemAddr = PC;
      end
      HOST_OWN: begin
        MemEn    = HostReq;
        MemWe    = HostReq & HostWe;
        MemAddr  = HostAddr;
        MemWData = HostWData;
      end
      default: begin
        MemEn = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_host_arbiter.sv
module tb_imem_host_arbiter;

  logic       Clk;
  logic       reset;
  logic       HostReq;
  logic       HostWe;
  logic [7:0] HostAddr;
  logic [7:0] HostWData;
  logic       HostGnt;
  logic       HostRValid;
  logic [7:0] PC;
  logic       FetchEn;
  logic       CoreHold;
  logic       CoreRst;
  logic       MemEn;
  logic       MemWe;
  logic [7:0] MemAddr;
  logic [7:0] MemWData;
  logic [8:0] LoadCount;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:255];
  logic [7:0] mem_rdata;
  logic [7:0] shadow [0:255];
  logic [7:0] exp_q [$];

  imem_host_arbiter #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .DRAIN_CYC (2),
    .RST_CYC   (3)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .HostReq    (HostReq),
    .HostWe     (HostWe),
    .HostAddr   (HostAddr),
    .HostWData  (HostWData),
    .HostGnt    (HostGnt),
    .HostRValid (HostRValid),
    .PC         (PC),
    .FetchEn    (FetchEn),
    .CoreHold   (CoreHold),
    .CoreRst    (CoreRst),
    .MemEn      (MemEn),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .LoadCount  (LoadCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous single-port memory, 1-cycle read latency.
  always @(posedge Clk) begin
    if (MemEn) begin
      if (MemWe) mem[MemAddr] <= MemWData;
      mem_rdata <= mem[MemAddr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; HostReq = 0; HostWe = 0; HostAddr = '0; HostWData = '0;
    PC = '0; FetchEn = 0;
    tick(); tick();
    total++; if (HostGnt !== 1'b0) $display("FAIL reset_gnt got=%b exp=0", HostGnt); else passed++;
    total++; if (HostRValid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", HostRValid); else passed++;
    total++; if (CoreHold !== 1'b0) $display("FAIL reset_hold got=%b exp=0", CoreHold); else passed++;
    total++; if (CoreRst !== 1'b0) $display("FAIL reset_crst got=%b exp=0", CoreRst); else passed++;
    total++; if (LoadCount !== 9'd0) $display("FAIL reset_count got=%0d exp=0", LoadCount); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_run_fetch();
    FetchEn = 1; PC = 8'h05;
    #1;
    total++; if (MemEn !== 1'b1) $display("FAIL run_memen got=%b exp=1", MemEn); else passed++;
    total++; if (MemAddr !== 8'h05) $display("FAIL run_addr got=%h exp=05", MemAddr); else passed++;
    total++; if (MemWe !== 1'b0) $display("FAIL run_we got=%b exp=0", MemWe); else passed++;
    total++; if (HostGnt !== 1'b0) $display("FAIL run_gnt got=%b exp=0", HostGnt); else passed++;
    total++; if (CoreHold !== 1'b0) $display("FAIL run_hold got=%b exp=0", CoreHold); else passed++;
    FetchEn = 0; PC = 8'h3A;
    #1;
    total++; if (MemEn !== 1'b0) $display("FAIL run_idle_memen got=%b exp=0", MemEn); else passed++;
    total++; if (MemAddr !== 8'h3A) $display("FAIL run_idle_addr got=%h exp=3a", MemAddr); else passed++;
    FetchEn = 1; PC = 8'h05;
    tick();
  endtask

  task automatic test_host_acquire();
    HostReq = 1; HostWe = 0; HostAddr = '0;
    #1;
    total++; if (CoreHold !== 1'b0) $display("FAIL acq_hold_early got=%b exp=0", CoreHold); else passed++;
    tick();
    total++; if (CoreHold !== 1'b1) $display("FAIL acq_hold got=%b exp=1", CoreHold); else passed++;
    total++; if (HostGnt !== 1'b0) $display("FAIL acq_gnt_d1 got=%b exp=0", HostGnt); else passed++;
    total++; if (MemEn !== 1'b0) $display("FAIL acq_drain_memen1 got=%b exp=0", MemEn); else passed++;
    tick();
    total++; if (HostGnt !== 1'b0) $display("FAIL acq_gnt_d2 got=%b exp=0", HostGnt); else passed++;
    total++; if (MemEn !== 1'b0) $display("FAIL acq_drain_memen2 got=%b exp=0", MemEn); else passed++;
    tick();
    total++; if (HostGnt !== 1'b1) $display("FAIL acq_gnt got=%b exp=1", HostGnt); else passed++;
    total++; if (CoreHold !== 1'b1) $display("FAIL acq_hold_own got=%b exp=1", CoreHold); else passed++;
    total++; if (LoadCount !== 9'd0) $display("FAIL acq_count got=%0d exp=0", LoadCount); else passed++;
  endtask

  task automatic test_host_load();
    logic [7:0] addrs [2];
    logic [7:0] datas [2];
    addrs[0] = 8'h00; datas[0] = 8'hD3;
    addrs[1] = 8'h01; datas[1] = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      HostWe = 1; HostAddr = addrs[i]; HostWData = datas[i];
      #1;
      total++; if (MemEn !== 1'b1 || MemWe !== 1'b1) $display("FAIL load_we[%0d] got en=%b we=%b exp 1/1", i, MemEn, MemWe); else passed++;
      total++; if (MemAddr !== addrs[i] || MemWData !== datas[i]) $display("FAIL load_port[%0d] got %h:%h exp %h:%h", i, MemAddr, MemWData, addrs[i], datas[i]); else passed++;
      shadow[addrs[i]] = datas[i];
      tick();
      total++; if (HostRValid !== 1'b0) $display("FAIL load_rvalid[%0d] got=%b exp=0", i, HostRValid); else passed++;
    end
    total++; if (LoadCount !== 9'd2) $display("FAIL load_count got=%0d exp=2", LoadCount); else passed++;
  endtask

  task automatic test_host_read();
    bit seen;
    logic [7:0] expv;
    HostWe = 0; HostAddr = 8'h00;
    #1;
    total++; if (MemEn !== 1'b1 || MemWe !== 1'b0) $display("FAIL read_port got en=%b we=%b exp 1/0", MemEn, MemWe); else passed++;
    exp_q.push_back(shadow[8'h00]);
    tick();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (HostRValid === 1'b1) begin seen = 1; break; end
      tick();
    end
    total++;
    if (!seen || exp_q.size() == 0) begin
      $display("FAIL read_timeout got rvalid=%b exp=1", HostRValid);
    end else begin
      expv = exp_q.pop_front();
      if (mem_rdata !== expv) $display("FAIL read_data got=%h exp=%h", mem_rdata, expv); else passed++;
    end
  endtask

  task automatic test_release();
    int cnt;
    HostReq = 0; HostWe = 0; FetchEn = 1; PC = 8'h22;
    #1;
    total++; if (MemEn !== 1'b0) $display("FAIL rel_idle_memen got=%b exp=0", MemEn); else passed++;
    tick();
    total++; if (HostGnt !== 1'b0) $display("FAIL rel_gnt got=%b exp=0", HostGnt); else passed++;
    total++; if (HostRValid !== 1'b0) $display("FAIL rel_rvalid got=%b exp=0", HostRValid); else passed++;
    total++; if (CoreHold !== 1'b1) $display("FAIL rel_hold got=%b exp=1", CoreHold); else passed++;
    total++; if (MemEn !== 1'b0) $display("FAIL rel_memen got=%b exp=0", MemEn); else passed++;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (CoreRst !== 1'b1) break;
      cnt++;
      tick();
    end
    total++; if (cnt != 3) $display("FAIL rel_crst_len got=%0d exp=3", cnt); else passed++;
    total++; if (CoreRst !== 1'b0 || CoreHold !== 1'b0) $display("FAIL rel_end got rst=%b hold=%b exp 0/0", CoreRst, CoreHold); else passed++;
    total++; if (MemEn !== 1'b1 || MemAddr !== 8'h22) $display("FAIL rel_fetch got en=%b addr=%h exp 1/22", MemEn, MemAddr); else passed++;
    total++; if (LoadCount !== 9'd2) $display("FAIL rel_count got=%0d exp=2", LoadCount); else passed++;
  endtask

  task automatic test_drain_abort();
    bit seen_gnt, seen_rst;
    HostReq = 1;
    tick();
    total++; if (CoreHold !== 1'b1) $display("FAIL abort_hold got=%b exp=1", CoreHold); else passed++;
    HostReq = 0;
    seen_gnt = 0; seen_rst = 0;
    tick();
    total++; if (CoreHold !== 1'b0) $display("FAIL abort_unhold got=%b exp=0", CoreHold); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (HostGnt === 1'b1) seen_gnt = 1;
      if (CoreRst === 1'b1) seen_rst = 1;
      tick();
    end
    total++; if (seen_gnt || seen_rst) $display("FAIL abort_pulses got gnt=%b rst=%b exp 0/0", seen_gnt, seen_rst); else passed++;
    total++; if (LoadCount !== 9'd2) $display("FAIL abort_count got=%0d exp=2", LoadCount); else passed++;
    total++; if (MemEn !== 1'b1 || MemAddr !== 8'h22) $display("FAIL abort_fetch got en=%b addr=%h exp 1/22", MemEn, MemAddr); else passed++;
  endtask

  task automatic test_back_to_back();
    HostReq = 1; HostWe = 0;
    tick(); tick(); tick();
    total++; if (HostGnt !== 1'b1) $display("FAIL b2b_gnt1 got=%b exp=1", HostGnt); else passed++;
    total++; if (LoadCount !== 9'd0) $display("FAIL b2b_clear got=%0d exp=0", LoadCount); else passed++;
    HostWe = 1; HostAddr = 8'h40; HostWData = 8'hA5; shadow[8'h40] = 8'hA5;
    tick();
    total++; if (LoadCount !== 9'd1) $display("FAIL b2b_count1 got=%0d exp=1", LoadCount); else passed++;
    HostReq = 0; HostWe = 0;
    tick();
    HostReq = 1;
    tick(); tick();
    total++; if (CoreRst !== 1'b1 || HostGnt !== 1'b0) $display("FAIL b2b_ignore got rst=%b gnt=%b exp 1/0", CoreRst, HostGnt); else passed++;
    tick();
    total++; if (CoreRst !== 1'b0 || CoreHold !== 1'b0) $display("FAIL b2b_run got rst=%b hold=%b exp 0/0", CoreRst, CoreHold); else passed++;
    tick();
    total++; if (CoreHold !== 1'b1 || HostGnt !== 1'b0) $display("FAIL b2b_drain got hold=%b gnt=%b exp 1/0", CoreHold, HostGnt); else passed++;
    tick(); tick();
    total++; if (HostGnt !== 1'b1) $display("FAIL b2b_gnt2 got=%b exp=1", HostGnt); else passed++;
    HostWe = 1;
    for (int i = 0; i < 515; i++) begin
      HostAddr = 8'(i); HostWData = 8'(i + 3);
      shadow[8'(i)] = 8'(i + 3);
      tick();
    end
    total++; if (LoadCount !== 9'h1FF) $display("FAIL b2b_saturate got=%0d exp=511", LoadCount); else passed++;
    HostReq = 0; HostWe = 0;
    repeat (5) tick();
    total++; if (CoreRst !== 1'b0 || CoreHold !== 1'b0) $display("FAIL b2b_done got rst=%b hold=%b exp 0/0", CoreRst, CoreHold); else passed++;
  endtask

  task automatic test_reset_mid_session();
    bit seen_rst;
    logic [7:0] expv;
    HostReq = 1; HostWe = 0; FetchEn = 0;
    tick(); tick(); tick();
    total++; if (HostGnt !== 1'b1) $display("FAIL rmid_gnt got=%b exp=1", HostGnt); else passed++;
    HostWe = 1;
    for (int i = 0; i < 5; i++) begin
      HostAddr = 8'h10 + 8'(i); HostWData = 8'h60 + 8'(i);
      shadow[8'h10 + 8'(i)] = 8'h60 + 8'(i);
      tick();
    end
    total++; if (LoadCount !== 9'd5) $display("FAIL rmid_count5 got=%0d exp=5", LoadCount); else passed++;
    reset = 1;
    #1;
    total++; if (HostGnt !== 1'b0 || CoreHold !== 1'b0 || CoreRst !== 1'b0) $display("FAIL rmid_async got gnt=%b hold=%b rst=%b exp 0/0/0", HostGnt, CoreHold, CoreRst); else passed++;
    total++; if (LoadCount !== 9'd0 || HostRValid !== 1'b0) $display("FAIL rmid_async_cnt got cnt=%0d rv=%b exp 0/0", LoadCount, HostRValid); else passed++;
    total++; if (MemEn !== 1'b0 || MemWe !== 1'b0) $display("FAIL rmid_port got en=%b we=%b exp 0/0", MemEn, MemWe); else passed++;
    HostReq = 0; HostWe = 0;
    tick();
    reset = 0;
    seen_rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (CoreRst === 1'b1 || CoreHold === 1'b1) seen_rst = 1;
    end
    total++; if (seen_rst) $display("FAIL rmid_no_pulse got pulse=1 exp=0"); else passed++;
    FetchEn = 1; PC = 8'h12;
    #1;
    exp_q.push_back(shadow[8'h12]);
    tick();
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL rmid_fetch got empty queue exp entry");
    end else begin
      expv = exp_q.pop_front();
      if (mem_rdata !== expv) $display("FAIL rmid_fetch got=%h exp=%h", mem_rdata, expv); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_run_fetch();
    test_host_acquire();
    test_host_load();
    test_host_read();
    test_release();
    test_drain_abort();
    test_back_to_back();
    test_reset_mid_session();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_host_arbiter.md
Name: imem_host_arbiter

Overview:
- Shares the single-port instruction memory between the core fetch path and an external host program loader.
- In normal operation the core owns the port and fetches at PC.
- On a host request, the block stalls the core, drains any in-flight fetch, grants the port to the host for reads and writes, then resets the core so it restarts from the freshly loaded program.

Parameters:
- ADDR_W, 8, instruction memory address width (equals PC width).
- DATA_W, 8, instruction width (4-bit opcode + operand).
- DRAIN_CYC, 2, cycles held in DRAIN before the host is granted; range 1..15.
- RST_CYC, 3, cycles CoreRst is held high in RELEASE; range 1..15.

Ports:
- Clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- HostReq  in  1  host requests ownership of the memory port; level, held for the whole session
- HostWe  in  1  host write strobe; valid only while HostGnt=1
- HostAddr  in  ADDR_W  host access address
- HostWData  in  DATA_W  host write data
- HostGnt  out  1  host owns the memory port (registered)
- HostRValid  out  1  MemRData holds host read data this cycle (registered)
- PC  in  ADDR_W  core fetch address
- FetchEn  in  1  core fetch request (the core's LoadIR)
- CoreHold  out  1  stall core: the core must treat the current instruction as HALT (registered)
- CoreRst  out  1  core reset pulse after a host session (registered)
- MemEn  out  1  memory port enable
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- LoadCount  out  ADDR_W+1  number of host writes in the most recent session; saturating

Behaviour:
- Memory is synchronous with 1-cycle read latency. MemRData is wired externally to both the core IR and the host.
- States are RUN, DRAIN, HOST_OWN and RELEASE. A 4-bit down-counter (tmr) serves both DRAIN and RELEASE.
- Reset values: state RUN, HostGnt=0, HostRValid=0, CoreHold=0, CoreRst=0, LoadCount=0, tmr=0.
- Port mux (combinational on state):
  - RUN: MemEn=FetchEn, MemWe=0, MemAddr=PC.
  - HOST_OWN: MemEn=HostReq, MemWe=HostReq&HostWe, MemAddr=HostAddr, MemWData=HostWData.
  - DRAIN and RELEASE: MemEn=0, MemWe=0.
  - Don't-care data outputs are driven to 0.
- RUN: if HostReq=1, go to DRAIN, set CoreHold=1, load tmr=DRAIN_CYC-1.
- DRAIN:
  - If HostReq=0, abort to RUN and clear CoreHold. No CoreRst, memory untouched.
  - Else if tmr==0, go to HOST_OWN, set HostGnt=1, clear LoadCount.
  - Else decrement tmr.
- HostGnt first reads 1 exactly DRAIN_CYC+1 rising edges after the edge that samples HostReq=1 in RUN.
- HOST_OWN:
  - Each cycle with HostReq=1 and HostWe=1 writes memory and increments LoadCount, saturating at 2^(ADDR_W+1)-1.
  - A cycle with HostReq=1 and HostWe=0 is a read. HostRValid=1 in the following cycle only.
  - If HostReq=0, go to RELEASE: HostGnt=0, CoreRst=1, load tmr=RST_CYC-1. The memory port is idle that cycle.
- RELEASE:
  - CoreRst stays high for exactly RST_CYC cycles.
  - When tmr==0, go to RUN: CoreRst=0, CoreHold=0.
  - HostReq is ignored while in RELEASE. If HostReq is high on entry to RUN, the next edge starts a new DRAIN.
- HostRValid is never 1 outside the cycle after a HOST_OWN read. A read on the last HOST_OWN cycle before HostReq falls is impossible, because MemEn requires HostReq.
- CoreHold and HostGnt are mutually consistent: HostGnt=1 implies CoreHold=1.
- Core fetch requests outside RUN are dropped. The core is stalled, so this is not an error.
- Asynchronous reset mid-session returns to RUN immediately with all outputs at reset values. No CoreRst pulse is generated, and partially loaded memory content stands.
- Illegal or unreachable state encodings go to RUN.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the arb_state_t enum (RUN, DRAIN, HOST_OWN, RELEASE);
  - the ISA opcode constants (NOP 4'b0000, HALT 4'b1111, ...) already used by the controller;
  - the ADDR_W/DATA_W defaults.
- One natural sub-module: arb_hold_timer, a 4-bit loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Reset then RUN with FetchEn=1, PC=8'h05 -> MemEn=1, MemAddr=8'h05, MemWe=0, HostGnt=0, CoreHold=0.
- HostReq rises at edge N (DRAIN_CYC=2) -> CoreHold=1 after N+1; HostGnt=1 after N+3; MemEn=0 during DRAIN.
- Granted host writes 8'hD3 @0x00, 8'h0F @0x01, then reads 0x00 -> MemWe pulses twice; HostRValid=1 next cycle with MemRData=8'hD3; LoadCount=2.
- HostReq drops (RST_CYC=3) -> HostGnt=0 and CoreRst=1 for exactly 3 cycles; then CoreRst=0, CoreHold=0, MemAddr follows PC again.
- HostReq pulsed for 1 cycle (drops in DRAIN) -> returns to RUN, HostGnt never 1, CoreRst never 1, LoadCount unchanged.
- reset asserted mid-HOST_OWN after 5 writes -> HostGnt/CoreHold/CoreRst/LoadCount=0 immediately; state RUN after release; no CoreRst pulse.
